// File: rtl/fp32toint_pipe.sv
// Two-stage IEEE-754 binary32 to int32/uint32 converter with valid/ready handshakes.
// Stage 1 aligns the significand and captures guard/sticky; stage 2 rounds, range-checks and sets flags.
module fp32toint_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_signed,
    input  logic        in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_invalid,
    output logic        out_inexact
);

    // RNE increment: round up on guard when sticky is set or on a tie with an odd lsb.
    function automatic logic round_inc(input logic rtz, input logic guard,
                                       input logic sticky, input logic lsb);
        round_inc = ~rtz & guard & (sticky | lsb);
    endfunction

    // Stage-1 register set
    logic        s1_valid_q,  s1_valid_d;
    logic        s1_sign_q;
    logic        s1_signed_q;
    logic        s1_rm_q;
    logic [31:0] s1_int_q,    s1_int_d;
    logic        s1_guard_q,  s1_guard_d;
    logic        s1_sticky_q, s1_sticky_d;
    logic        s1_big_q,    s1_big_d;
    logic        s1_nan_q,    s1_nan_d;
    logic        s1_inf_q,    s1_inf_d;

    // Stage-2 register set (drives the outputs directly)
    logic        s2_valid_q,  s2_valid_d;
    logic [31:0] s2_data_q,   s2_data_d;
    logic        s2_inv_q,    s2_inv_d;
    logic        s2_inex_q,   s2_inex_d;

    logic        s2_free_s;
    logic        s1_adv_s;
    logic        accept_s;

    logic [7:0]  exp_s;
    logic [22:0] man_s;
    logic [23:0] sig_s;
    logic [5:0]  sh_s;
    logic [63:0] shifted_s;

    logic        inc_s;
    logic [32:0] mag_s;
    logic [31:0] sat_s;
    logic        ovf_s;

    assign s2_free_s = ~s2_valid_q | out_ready;
    assign s1_adv_s  = s1_valid_q & s2_free_s;
    assign in_ready  = ~s1_valid_q | s2_free_s;
    assign accept_s  = in_valid & in_ready;

    assign exp_s = in_data[30:23];
    assign man_s = in_data[22:0];
    assign sig_s = {1'b1, man_s};
    // Shift places the value with 32 fraction bits: amount = E-118, valid for E in 126..158 (only low 6 bits needed).
    assign sh_s  = exp_s[5:0] - 6'd54;

    // Stage-1 decode and alignment into integer part, guard and sticky
    always_comb begin
        s1_int_d    = 32'd0;
        s1_guard_d  = 1'b0;
        s1_sticky_d = 1'b0;
        s1_big_d    = 1'b0;
        s1_nan_d    = 1'b0;
        s1_inf_d    = 1'b0;
        shifted_s   = 64'd0;
        if (exp_s == 8'd255) begin
            s1_nan_d = (man_s != 23'd0);
            s1_inf_d = (man_s == 23'd0);
        end else if (exp_s >= 8'd159) begin
            s1_big_d = 1'b1;
        end else if (exp_s >= 8'd126) begin
            shifted_s   = {40'd0, sig_s} << sh_s;
            s1_int_d    = shifted_s[63:32];
            s1_guard_d  = shifted_s[31];
            s1_sticky_d = |shifted_s[30:0];
        end else if (exp_s == 8'd0) begin
            s1_sticky_d = (man_s != 23'd0);
        end else begin
            // Magnitude below 0.5 but nonzero: rounds to zero in both modes.
            s1_sticky_d = 1'b1;
        end
    end

    // Stage-1 occupancy
    always_comb begin
        s1_valid_d = s1_valid_q;
        if (accept_s) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage-1 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_signed_q <= 1'b0;
            s1_rm_q     <= 1'b0;
            s1_int_q    <= 32'd0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_big_q    <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept_s) begin
                s1_sign_q   <= in_data[31];
                s1_signed_q <= in_signed;
                s1_rm_q     <= in_rm;
                s1_int_q    <= s1_int_d;
                s1_guard_q  <= s1_guard_d;
                s1_sticky_q <= s1_sticky_d;
                s1_big_q    <= s1_big_d;
                s1_nan_q    <= s1_nan_d;
                s1_inf_q    <= s1_inf_d;
            end
        end
    end

    assign inc_s = round_inc(s1_rm_q, s1_guard_q, s1_sticky_q, s1_int_q[0]);
    assign mag_s = {1'b0, s1_int_q} + {32'd0, inc_s};

    // Stage-2 rounding, range check, saturation and flags
    always_comb begin
        s2_data_d = 32'd0;
        s2_inv_d  = 1'b0;
        s2_inex_d = 1'b0;
        ovf_s     = 1'b0;
        if (s1_signed_q) begin
            sat_s = s1_sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
            ovf_s = s1_sign_q ? (mag_s > 33'h0_8000_0000) : (mag_s > 33'h0_7FFF_FFFF);
        end else begin
            sat_s = s1_sign_q ? 32'h0000_0000 : 32'hFFFF_FFFF;
            ovf_s = s1_sign_q ? (mag_s != 33'd0) : mag_s[32];
        end
        if (s1_nan_q) begin
            s2_data_d = s1_signed_q ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            s2_inv_d  = 1'b1;
        end else if (s1_inf_q || s1_big_q || ovf_s) begin
            s2_data_d = sat_s;
            s2_inv_d  = 1'b1;
        end else begin
            s2_data_d = s1_sign_q ? (~mag_s[31:0] + 32'd1) : mag_s[31:0];
            s2_inex_d = s1_guard_q | s1_sticky_q;
        end
    end

    // Stage-2 occupancy
    always_comb begin
        s2_valid_d = s2_valid_q;
        if (s1_adv_s) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Stage-2 registers; result fields only change when a new result moves in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= 32'd0;
            s2_inv_q   <= 1'b0;
            s2_inex_q  <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s1_adv_s) begin
                s2_data_q <= s2_data_d;
                s2_inv_q  <= s2_inv_d;
                s2_inex_q <= s2_inex_d;
            end
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_data    = s2_data_q;
    assign out_invalid = s2_inv_q;
    assign out_inexact = s2_inex_q;

endmodule

// File: tb/tb_fp32toint_pipe.sv
// Directed bench for fp32toint_pipe: expectations queued on accept, checked when results emerge.
module tb_fp32toint_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_invalid;
    logic        out_inexact;

    typedef struct packed {
        logic [31:0] d;
        logic        inv;
        logic        inex;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] pop_cyc_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          accept_cnt = 0;
    logic [31:0] cyc_cnt = 32'd0;
    bit          lat_chk = 1'b1;
    logic [31:0] exp_d = 32'd0;
    logic        exp_inv = 1'b0;
    logic        exp_inex = 1'b0;
    logic        held_v = 1'b0;
    logic [31:0] held_d = 32'd0;
    logic        held_inv = 1'b0;
    logic        held_inex = 1'b0;

    fp32toint_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_signed  (in_signed),
        .in_rm      (in_rm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_invalid(out_invalid),
        .out_inexact(out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc_cnt = cyc_cnt + 32'd1;
        end
    end

    // Monitor: push on accept, pop/compare on output transfer, check stability under stall.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 1'b0;
            end else begin
                if (in_valid && in_ready) begin
                    sb_q.push_back({exp_d, exp_inv, exp_inex, cyc_cnt});
                    accept_cnt++;
                end
                if (out_valid) begin
                    if (held_v) begin
                        total++;
                        assert ({out_data, out_invalid, out_inexact} === {held_d, held_inv, held_inex})
                        else begin
                            bad++;
                            $error("FAIL stall_hold obs=%h/%b/%b exp=%h/%b/%b", out_data, out_invalid,
                                   out_inexact, held_d, held_inv, held_inex);
                        end
                    end
                    if (out_ready) begin
                        held_v = 1'b0;
                        total++;
                        assert (sb_q.size() != 0)
                        else begin
                            bad++;
                            $error("FAIL unexpected_out obs=%h exp=none", out_data);
                        end
                        if (sb_q.size() != 0) begin
                            mon_e = sb_q.pop_front();
                            pop_cyc_q.push_back(cyc_cnt);
                            total++;
                            assert ({out_data, out_invalid, out_inexact} === {mon_e.d, mon_e.inv, mon_e.inex})
                            else begin
                                bad++;
                                $error("FAIL result obs=%h inv=%b inex=%b exp=%h inv=%b inex=%b", out_data,
                                       out_invalid, out_inexact, mon_e.d, mon_e.inv, mon_e.inex);
                            end
                            if (lat_chk) begin
                                total++;
                                assert (cyc_cnt - mon_e.cyc === 32'd2)
                                else begin
                                    bad++;
                                    $error("FAIL latency obs=%0d exp=2", cyc_cnt - mon_e.cyc);
                                end
                            end
                        end
                    end else begin
                        held_v    = 1'b1;
                        held_d    = out_data;
                        held_inv  = out_invalid;
                        held_inex = out_inexact;
                    end
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic sg, input logic rm,
                        input logic [31:0] ed, input logic ei, input logic ex);
        int n;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = sg;
        in_rm     = rm;
        exp_d     = ed;
        exp_inv   = ei;
        exp_inex  = ex;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        assert (in_ready === 1'b1)
        else begin
            bad++;
            $error("FAIL send_timeout obs=%b exp=1 data=%h", in_ready, d);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, sb_q.size(), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_signed = 1'b0;
        in_rm     = 1'b0;
        out_ready = 1'b1;

        #12;
        chk("rst_out_valid",   {31'd0, out_valid},   32'd0);
        chk("rst_out_data",    out_data,             32'd0);
        chk("rst_out_invalid", {31'd0, out_invalid}, 32'd0);
        chk("rst_out_inexact", {31'd0, out_inexact}, 32'd0);
        chk("rst_in_ready",    {31'd0, in_ready},    32'd1);

        // First operand presented across reset release; accepted on the first edge after it.
        #4;
        in_valid  = 1'b1;
        in_data   = 32'h3FC0_0000;
        in_signed = 1'b1;
        in_rm     = 1'b0;
        exp_d     = 32'h0000_0002;
        exp_inv   = 1'b0;
        exp_inex  = 1'b1;
        #1;
        rst_n = 1'b1;

        send(32'h3FC0_0000, 1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b1);
        send(32'h4020_0000, 1'b1, 1'b0, 32'h0000_0002, 1'b0, 1'b1);
        send(32'hBFC0_0000, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1);
        send(32'hCF00_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
        send(32'h4F00_0000, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        send(32'h4F00_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
        send(32'h4F80_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send(32'h7FC0_0000, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        send(32'hFF80_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 1'b0);
        send(32'hBF80_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        send(32'hBE99_999A, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        send(32'h0000_0001, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        send(32'h8000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        send(32'h3F00_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        send(32'h3F40_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b1);
        send(32'h4060_0000, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b1);
        send(32'h4F7F_FFFF, 1'b0, 1'b0, 32'hFFFF_FF00, 1'b0, 1'b0);
        send(32'hCF00_0001, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 1'b0);
        send(32'h7F80_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send(32'h7FC0_0000, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send(32'h3FFF_FFFF, 1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b1);
        send(32'hBF00_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        send(32'h4B00_0001, 1'b1, 1'b0, 32'h0080_0001, 1'b0, 1'b0);
        send(32'hBF80_0000, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send(32'hFF80_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        send(32'h4F80_0000, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
        idle();
        drain("drain_main");

        // Backpressure: two accepted, then in_ready low while the output stalls.
        out_ready  = 1'b0;
        lat_chk    = 1'b0;
        accept_cnt = 0;
        pop_cyc_q.delete();
        send(32'h3F80_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h4000_0000, 1'b1, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_data  = 32'h4040_0000;
        exp_d    = 32'h0000_0003;
        exp_inv  = 1'b0;
        exp_inex = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_accepts", accept_cnt, 32'd2);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(32'h4080_0000, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0);
        idle();
        drain("drain_bp");
        chk("bp_total_accepts", accept_cnt, 32'd4);
        chk("bp_pop_count", pop_cyc_q.size(), 32'd4);
        if (pop_cyc_q.size() == 4) begin
            chk("bp_back_to_back", pop_cyc_q[3] - pop_cyc_q[0], 32'd3);
        end

        // Reset with two operands in flight.
        lat_chk = 1'b1;
        send(32'h4120_0000, 1'b1, 1'b0, 32'h0000_000A, 1'b0, 1'b0);
        send(32'h41A0_0000, 1'b1, 1'b0, 32'h0000_0014, 1'b0, 1'b0);
        idle();
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_out_data", out_data, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("no_stale", {31'd0, out_valid}, 32'd0);
        end
        send(32'h42C8_0000, 1'b1, 1'b0, 32'h0000_0064, 1'b0, 1'b0);
        idle();
        drain("drain_post_rst");
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
